vga_scan_engine: RTL and testbench

//  Parametrised VGA scan engine: pixel-strobe divider, H/V timing counters, sync generation and a

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_delay_line.sv | 26 ++
 rtl/vga_scan_engine.sv | 176 +++++++++++++++++
 tb/tb_vga_scan_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480 timing defaults, colour defaults and helpers for the VGA scan engine
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int COLOR_W_DEF = 4;
   localparam logic [3*COLOR_W_DEF-1:0] BG_COLOR_DEF = 12'hFFE;

   function automatic int h_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int v_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic logic [3*COLOR_W_DEF-1:0] rgb_pack(input logic [COLOR_W_DEF-1:0] r,
                                                         input logic [COLOR_W_DEF-1:0] g,
                                                         input logic [COLOR_W_DEF-1:0] b);
      return {r, g, b};
   endfunction

   // idx 2 = red, 1 = green, 0 = blue
   function automatic logic [COLOR_W_DEF-1:0] rgb_unpack(input logic [3*COLOR_W_DEF-1:0] rgb,
                                                         input int idx);
      return rgb[idx*COLOR_W_DEF +: COLOR_W_DEF];
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - strobe-enabled shift register aligning stage-0 decode with the pixel source
module vga_delay_line #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (en) begin
         stage_q[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_engine.sv
// rtl/vga_scan_engine.sv - VGA strobe divider, H/V counters, grid decode and latency-matched output stage
// Optional colour-bar test pattern enabled by defining VGA_TESTPAT_EN.
module vga_scan_engine
   import vga_pkg::*;
#(
   parameter int   CLK_DIV   = 4,
   parameter int   H_ACTIVE  = H_ACTIVE_DEF,
   parameter int   H_FP      = H_FP_DEF,
   parameter int   H_SYNC    = H_SYNC_DEF,
   parameter int   H_BP      = H_BP_DEF,
   parameter int   V_ACTIVE  = V_ACTIVE_DEF,
   parameter int   V_FP      = V_FP_DEF,
   parameter int   V_SYNC    = V_SYNC_DEF,
   parameter int   V_BP      = V_BP_DEF,
   parameter logic HS_POL    = 1'b0,
   parameter logic VS_POL    = 1'b0,
   parameter int   COLOR_W   = COLOR_W_DEF,
   parameter int   SRC_LAT   = 1,
   parameter int   GRID_N    = 4,
   parameter int   TILE_W    = $clog2(GRID_N),
   parameter int   TILE_LOG2 = 6,
   parameter int   GRID_X0   = 192,
   parameter int   GRID_Y0   = 112,
   parameter logic [3*COLOR_W-1:0] BG_COLOR = BG_COLOR_DEF
) (
   input  logic                   CLK100MHZ,
   input  logic                   reset,
   input  logic                   blank,
`ifdef VGA_TESTPAT_EN
   input  logic                   testpat,
`endif
   input  logic [3*COLOR_W-1:0]   pixel_color,
   output logic                   pix_stb,
   output logic [9:0]             x,
   output logic [9:0]             y,
   output logic [TILE_W-1:0]      tile_row,
   output logic [TILE_W-1:0]      tile_col,
   output logic                   in_grid,
   output logic                   frame_start,
   output logic [COLOR_W-1:0]     VGA_R,
   output logic [COLOR_W-1:0]     VGA_G,
   output logic [COLOR_W-1:0]     VGA_B,
   output logic                   VGA_HS,
   output logic                   VGA_VS,
   output logic                   de
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int DIV_W   = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] GX_BEG = 10'(GRID_X0);
   localparam logic [9:0] GX_END = 10'(GRID_X0 + (GRID_N << TILE_LOG2));
   localparam logic [9:0] GY_BEG = 10'(GRID_Y0);
   localparam logic [9:0] GY_END = 10'(GRID_Y0 + (GRID_N << TILE_LOG2));

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       x_q, x_d, y_q, y_d;

   always_comb begin
      div_d = div_q;
      x_d   = x_q;
      y_d   = y_q;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         div_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
      end else begin
         div_q <= div_d;
         x_q   <= x_d;
         y_q   <= y_d;
      end
   end

   // Stage-0 decode straight from the counters; this is what the pixel source is asked for.
   logic de0, hs0, vs0;
   assign pix_stb     = !reset && (div_q == DIV_LAST);
   assign frame_start = pix_stb && (x_q == '0) && (y_q == '0);
   assign de0         = (x_q < H_ACT) && (y_q < V_ACT);
   assign hs0         = (x_q >= HS_BEG) && (x_q < HS_END);
   assign vs0         = (y_q >= VS_BEG) && (y_q < VS_END);
   assign in_grid     = !reset && de0 && (x_q >= GX_BEG) && (x_q < GX_END)
                        && (y_q >= GY_BEG) && (y_q < GY_END);
   assign tile_col    = in_grid ? TILE_W'((x_q - GX_BEG) >> TILE_LOG2) : '0;
   assign tile_row    = in_grid ? TILE_W'((y_q - GY_BEG) >> TILE_LOG2) : '0;
   assign x           = x_q;
   assign y           = y_q;

   logic hs_dl, vs_dl, de_dl, grid_dl;
`ifdef VGA_TESTPAT_EN
   localparam int DL_W = 14;
   localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
   logic [9:0]      x_dl;
   logic [2:0]      bar;
   logic [DL_W-1:0] dl_in, dl_out;
   assign dl_in = {x_q, hs0, vs0, de0, in_grid};
   assign {x_dl, hs_dl, vs_dl, de_dl, grid_dl} = dl_out;
   assign bar = 3'(x_dl / BAR_W);
`else
   localparam int DL_W = 4;
   logic [DL_W-1:0] dl_in, dl_out;
   assign dl_in = {hs0, vs0, de0, in_grid};
   assign {hs_dl, vs_dl, de_dl, grid_dl} = dl_out;
`endif

   vga_delay_line #(
      .WIDTH (DL_W),
      .DEPTH (SRC_LAT)
   ) u_delay (
      .clk   (CLK100MHZ),
      .reset (reset),
      .en    (pix_stb),
      .d     (dl_in),
      .q     (dl_out)
   );

   logic [3*COLOR_W-1:0] rgb_d, rgb_q;
   logic                 hs_q, vs_q, de_q;

   always_comb begin
      rgb_d = '0;
      if (de_dl && !blank) begin
`ifdef VGA_TESTPAT_EN
         if (testpat) rgb_d = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
         else         rgb_d = grid_dl ? pixel_color : BG_COLOR;
`else
         rgb_d = grid_dl ? pixel_color : BG_COLOR;
`endif
      end
   end

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         rgb_q <= '0;
         hs_q  <= ~HS_POL;
         vs_q  <= ~VS_POL;
         de_q  <= 1'b0;
      end else if (pix_stb) begin
         rgb_q <= rgb_d;
         hs_q  <= hs_dl ? HS_POL : ~HS_POL;
         vs_q  <= vs_dl ? VS_POL : ~VS_POL;
         de_q  <= de_dl;
      end
   end

   assign VGA_R  = rgb_q[3*COLOR_W-1 -: COLOR_W];
   assign VGA_G  = rgb_q[2*COLOR_W-1 -: COLOR_W];
   assign VGA_B  = rgb_q[COLOR_W-1 -: COLOR_W];
   assign VGA_HS = hs_q;
   assign VGA_VS = vs_q;
   assign de     = de_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// tb/tb_vga_scan_engine.sv - directed checks of the VGA scan engine on a reduced 24x17 raster
`timescale 1ns/1ps
module tb_vga_scan_engine;
   import vga_pkg::*;

   localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
   localparam int VA = 12, VF = 1, VSY = 2, VB = 2;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic blank = 1'b0;
   always #5 clk = ~clk;

   logic [11:0] pcol;
   logic        stb, ing, fs, hs, vs, de;
   logic [9:0]  x, y;
   logic [1:0]  trow, tcol;
   logic [3:0]  r, g, b;
`ifdef VGA_TESTPAT_EN
   logic testpat = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   function automatic logic [11:0] tag(input logic [9:0] xx, input logic [9:0] yy);
      return {2'b10, xx[4:0], yy[4:0]};
   endfunction

   // Pixel-source model: answers each strobe's (x,y) request LAT strobes later.
   logic [11:0] hist [4];
   always @(posedge clk) if (stb) begin
      hist[0] <= tag(x, y);
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
   end
   assign pcol = hist[LAT-1];

   vga_scan_engine #(
      .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0),
      .COLOR_W(4), .SRC_LAT(LAT), .GRID_N(4), .TILE_LOG2(1), .GRID_X0(4), .GRID_Y0(2),
      .BG_COLOR(12'hFFE)
   ) dut (
      .CLK100MHZ(clk), .reset(rst), .blank(blank),
`ifdef VGA_TESTPAT_EN
      .testpat(testpat),
`endif
      .pixel_color(pcol), .pix_stb(stb), .x(x), .y(y), .tile_row(trow), .tile_col(tcol),
      .in_grid(ing), .frame_start(fs), .VGA_R(r), .VGA_G(g), .VGA_B(b),
      .VGA_HS(hs), .VGA_VS(vs), .de(de)
   );

   // Latency sweep: one engine per SRC_LAT, grid anchored at the origin.
   logic [3:0]  l_de;
   logic [11:0] l_rgb [4];
   for (genvar gi = 0; gi < 4; gi++) begin : g_lat
      logic        ls, lig, lfs, lhs, lvs, lde;
      logic [9:0]  lx, ly;
      logic [1:0]  lr, lc;
      logic [3:0]  rr, gg, bb;
      logic [11:0] lh [4];
      always @(posedge clk) if (ls) begin
         lh[0] <= tag(lx, ly);
         for (int i = 1; i < 4; i++) lh[i] <= lh[i-1];
      end
      vga_scan_engine #(
         .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
         .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0),
         .COLOR_W(4), .SRC_LAT(gi + 1), .GRID_N(4), .TILE_LOG2(1), .GRID_X0(0), .GRID_Y0(0),
         .BG_COLOR(12'hFFE)
      ) u_lat (
         .CLK100MHZ(clk), .reset(rst), .blank(1'b0),
`ifdef VGA_TESTPAT_EN
         .testpat(1'b0),
`endif
         .pixel_color(lh[gi]), .pix_stb(ls), .x(lx), .y(ly), .tile_row(lr), .tile_col(lc),
         .in_grid(lig), .frame_start(lfs), .VGA_R(rr), .VGA_G(gg), .VGA_B(bb),
         .VGA_HS(lhs), .VGA_VS(lvs), .de(lde)
      );
      assign l_de[gi]  = lde;
      assign l_rgb[gi] = {rr, gg, bb};
   end

   typedef struct {
      int          px, py;
      logic        e_ig;
      int          e_tr, e_tc;
      logic        e_de, e_hs, e_vs;
      logic [11:0] e_rgb;
   } vec_t;
   vec_t tbl [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic to_stb();
      int guard = 0;
      while (stb !== 1'b1 && guard < 16) begin
         @(negedge clk);
         guard++;
      end
      if (stb !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL strobe_timeout: got no pix_stb in %0d clocks expected one", guard);
      end
   endtask

   task automatic past_stb();
      @(negedge clk);
   endtask

   task automatic adv(input int n);
      for (int i = 0; i < n; i++) begin
         to_stb();
         past_stb();
      end
   endtask

   task automatic seek(input int xx, input int yy);
      int guard = 0;
      to_stb();
      while (!(x == 10'(xx) && y == 10'(yy)) && guard < 500) begin
         past_stb();
         to_stb();
         guard++;
      end
      chk("seek_xy", {6'd0, x, 6'd0, y}, {6'd0, 10'(xx), 6'd0, 10'(yy)});
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, lows, px;
      logic exp_hs;

      tbl[0]  = '{0, 0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 12'hFFE};
      tbl[1]  = '{15, 1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 12'hFFE};
      tbl[2]  = '{18, 1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 12'h000};
      tbl[3]  = '{21, 1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 12'h000};
      tbl[4]  = '{4, 2, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, tag(10'd4, 10'd2)};
      tbl[5]  = '{3, 5, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 12'hFFE};
      tbl[6]  = '{7, 6, 1'b1, 2, 1, 1'b1, 1'b1, 1'b1, tag(10'd7, 10'd6)};
      tbl[7]  = '{12, 8, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 12'hFFE};
      tbl[8]  = '{11, 9, 1'b1, 3, 3, 1'b1, 1'b1, 1'b1, tag(10'd11, 10'd9)};
      tbl[9]  = '{5, 10, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 12'hFFE};
      tbl[10] = '{2, 12, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 12'h000};
      tbl[11] = '{2, 13, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 12'h000};
      tbl[12] = '{19, 14, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 12'h000};
      tbl[13] = '{0, 15, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 12'h000};

      // Reset values, then first strobe on the fourth clock after release.
      repeat (3) @(negedge clk);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_stb", stb, 0);
      chk("rst_fs", fs, 0);
      chk("rst_ingrid", ing, 0);
      chk("rst_rgb", {r, g, b}, 0);
      chk("rst_de", de, 0);
      chk("rst_hs", hs, 1);
      chk("rst_vs", vs, 1);
      rst = 1'b0;
      @(negedge clk);
      chk("stb_clk2", stb, 0);
      @(negedge clk);
      chk("stb_clk3", stb, 0);
      @(negedge clk);
      chk("stb_clk4", stb, 1);
      chk("fs_first", fs, 1);

      n = 0;
      while (n < 1000) begin
         past_stb();
         to_stb();
         n++;
         if (n == 24) chk("line_wrap_xy", {x, y}, {10'd0, 10'd1});
         if (fs) break;
      end
      chk("frame_period", n, 408);

      for (int i = 0; i < 14; i++) begin
         seek(tbl[i].px, tbl[i].py);
         chk($sformatf("v%0d_ingrid", i), ing, tbl[i].e_ig);
         chk($sformatf("v%0d_tile", i), {trow, tcol}, {2'(tbl[i].e_tr), 2'(tbl[i].e_tc)});
         adv(LAT + 1);
         chk($sformatf("v%0d_de", i), de, tbl[i].e_de);
         chk($sformatf("v%0d_hs", i), hs, tbl[i].e_hs);
         chk($sformatf("v%0d_vs", i), vs, tbl[i].e_vs);
         chk($sformatf("v%0d_rgb", i), {r, g, b}, tbl[i].e_rgb);
      end

      // HS low for exactly three strobes; pins trail counters by LAT+1 strobes.
      seek(17, 3);
      lows = 0;
      for (int k = 1; k <= 8; k++) begin
         to_stb();
         past_stb();
         exp_hs = !((14 + k) >= 18 && (14 + k) <= 20);
         chk($sformatf("hs_seq%0d", k), hs, exp_hs);
         if (hs == 1'b0) lows++;
      end
      chk("hs_low_width", lows, 3);

      // blank takes effect on the next strobe's output register only.
      seek(8, 4);
      adv(LAT + 1);
      chk("blank0_rgb", {r, g, b}, tag(10'd8, 10'd4));
      blank = 1'b1;
      adv(1);
      chk("blank1_rgb", {r, g, b}, 0);
      chk("blank1_de", de, 1);
      chk("blank1_hs", hs, 1);
      blank = 1'b0;
      adv(1);
      chk("blank2_rgb", {r, g, b}, tag(10'd10, 10'd4));

      seek(0, 0);
      for (int m = 1; m <= 6; m++) begin
         past_stb();
         for (int i = 0; i < 4; i++) begin
            px = m - 1 - (i + 1);
            chk($sformatf("lat%0d_n%0d_de", i + 1, m), l_de[i], (px >= 0) ? 1 : 0);
            chk($sformatf("lat%0d_n%0d_rgb", i + 1, m), l_rgb[i],
                (px >= 0) ? tag(10'(px), 10'd0) : 12'h000);
         end
         to_stb();
      end

`ifdef VGA_TESTPAT_EN
      testpat = 1'b1;
      seek(0, 1);
      adv(LAT + 1);
      chk("bar0_rgb", {r, g, b}, 12'h000);
      seek(14, 1);
      adv(LAT + 1);
      chk("bar7_rgb", {r, g, b}, 12'hFFF);
      testpat = 1'b0;
`endif

      // Asynchronous reset mid-frame, then restart from (0,0).
      seek(10, 5);
      #2 rst = 1'b1;
      #1;
      chk("arst_xy", {x, y}, 0);
      chk("arst_rgb", {r, g, b}, 0);
      chk("arst_de", de, 0);
      chk("arst_sync", {hs, vs}, 2'b11);
      chk("arst_stb", {stb, fs}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("arst_stb_clk3", stb, 0);
      @(negedge clk);
      chk("arst_restart", {stb, fs, x, y}, {2'b11, 20'd0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
      $finish;
   end

endmodule
